// File: rtl/inagu_nd.sv
// N-dimensional job address generator: pairs data/weight bank addresses per enabled cycle.
// Latency: the first address is presented in the cycle after start; one address pair per valid cycle.
// Backpressure: en low stalls every counter and the address registers; valid follows en while RUN.
module inagu_nd #(
   parameter int BPREC    = 6,
   parameter int BWBANKA  = 9,
   parameter int BDBANKA  = 15,
   parameter int BWLENGTH = 8,
   parameter int NDIM     = 4,
   parameter int BACC     = 2
) (
   input  logic                      clk,
   input  logic                      clr,
   input  logic                      start,
   input  logic                      en,
   input  logic [BPREC-1:0]          iprecision,
   input  logic [BPREC-1:0]          wprecision,
   input  logic [BDBANKA-1:0]        ibaseaddr,
   input  logic [BWBANKA-1:0]        wbaseaddr,
   input  logic [NDIM*BDBANKA-1:0]   istride,
   input  logic [NDIM*BWBANKA-1:0]   wstride,
   input  logic [NDIM*BWLENGTH-1:0]  length,
   input  logic [BACC-1:0]           acc_lvl,
   output logic                      valid,
   output logic [BDBANKA-1:0]        iaddr_out,
   output logic [BWBANKA-1:0]        waddr_out,
   output logic                      imsb,
   output logic                      wmsb,
   output logic                      sh_out,
   output logic                      acc_done,
   output logic                      busy,
   output logic                      done
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t state_q;
   logic   busy_q;
   logic   done_q;

   // Job configuration, captured at start. Precisions are stored as max count (p-1).
   logic [BPREC-1:0]    pdm_q;
   logic [BPREC-1:0]    pwm_q;
   logic [BDBANKA-1:0]  ibase_q;
   logic [BWBANKA-1:0]  wbase_q;
   logic [BDBANKA-1:0]  istr_q [NDIM];
   logic [BWBANKA-1:0]  wstr_q [NDIM];
   logic [BWLENGTH-1:0] len_q  [NDIM];
   logic [BACC-1:0]     acc_q;

   // Loop counters and the running per-dimension offsets (ck * stride_k).
   logic [BPREC-1:0]    bd_q, bd_d;
   logic [BPREC-1:0]    bw_q, bw_d;
   logic [BWLENGTH-1:0] c_q    [NDIM];
   logic [BWLENGTH-1:0] c_d    [NDIM];
   logic [BDBANKA-1:0]  ioff_q [NDIM];
   logic [BDBANKA-1:0]  ioff_d [NDIM];
   logic [BWBANKA-1:0]  woff_q [NDIM];
   logic [BWBANKA-1:0]  woff_d [NDIM];
   logic [BDBANKA-1:0]  iaddr_q, iaddr_d;
   logic [BWBANKA-1:0]  waddr_q, waddr_d;

   logic              adv;
   logic              bd_max;
   logic              bw_max;
   logic [NDIM:0]     carry;
   logic              last;
   logic              acc_hit;

   // clr also masks valid so nothing is consumed in a reset cycle.
   assign adv    = (state_q == ST_RUN) & en & ~clr;
   assign bd_max = (bd_q == pdm_q);
   assign bw_max = (bw_q == pwm_q);

   // Carry chain and next counter / offset / address values.
   // carry[k] means every loop inside dimension k is at its max; carry[NDIM] marks the final address.
   always_comb begin
      bd_d    = bd_max ? '0 : bd_q + 1'b1;
      bw_d    = bw_q;
      if (bd_max) begin
         bw_d = bw_max ? '0 : bw_q + 1'b1;
      end
      carry    = '0;
      carry[0] = bd_max & bw_max;
      for (int k = 0; k < NDIM; k++) begin
         c_d[k]    = c_q[k];
         ioff_d[k] = ioff_q[k];
         woff_d[k] = woff_q[k];
         carry[k+1] = carry[k] & (c_q[k] == len_q[k]);
         if (carry[k]) begin
            if (c_q[k] == len_q[k]) begin
               c_d[k]    = '0;
               ioff_d[k] = '0;
               woff_d[k] = '0;
            end else begin
               c_d[k]    = c_q[k] + 1'b1;
               ioff_d[k] = ioff_q[k] + istr_q[k];
               woff_d[k] = woff_q[k] + wstr_q[k];
            end
         end
      end
      iaddr_d = ibase_q + BDBANKA'(bd_d);
      waddr_d = wbase_q + BWBANKA'(bw_d);
      for (int k = 0; k < NDIM; k++) begin
         iaddr_d = iaddr_d + ioff_d[k];
         waddr_d = waddr_d + woff_d[k];
      end
      acc_hit = 1'b0;
      for (int k = 0; k < NDIM; k++) begin
         if (k == int'(acc_q)) begin
            acc_hit = carry[k+1];
         end
      end
   end

   assign last = carry[NDIM];

   assign valid     = adv;
   assign iaddr_out = iaddr_q;
   assign waddr_out = waddr_q;
   assign imsb      = adv & (bd_q == '0);
   assign wmsb      = adv & (bw_q == '0);
   assign sh_out    = adv & bd_max;
   assign acc_done  = adv & acc_hit;
   assign busy      = busy_q;
   assign done      = done_q;

   // Job FSM: IDLE -> RUN on start, RUN -> DONE after the final address, DONE pulses done for one cycle.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= ST_IDLE;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b1;
               end
            end
            ST_RUN: begin
               if (adv && last) begin
                  state_q <= ST_DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
            end
            ST_DONE: begin
               state_q <= ST_IDLE;
               done_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
            end
         endcase
      end
   end

   // Capture job configuration on an accepted start; a precision of 0 behaves as 1.
   always_ff @(posedge clk) begin
      if (clr) begin
         pdm_q   <= '0;
         pwm_q   <= '0;
         ibase_q <= '0;
         wbase_q <= '0;
         acc_q   <= '0;
         for (int k = 0; k < NDIM; k++) begin
            istr_q[k] <= '0;
            wstr_q[k] <= '0;
            len_q[k]  <= '0;
         end
      end else if (state_q == ST_IDLE && start) begin
         pdm_q   <= (iprecision == '0) ? '0 : iprecision - 1'b1;
         pwm_q   <= (wprecision == '0) ? '0 : wprecision - 1'b1;
         ibase_q <= ibaseaddr;
         wbase_q <= wbaseaddr;
         acc_q   <= (int'(acc_lvl) >= NDIM) ? BACC'(NDIM - 1) : acc_lvl;
         for (int k = 0; k < NDIM; k++) begin
            istr_q[k] <= istride[k*BDBANKA +: BDBANKA];
            wstr_q[k] <= wstride[k*BWBANKA +: BWBANKA];
            len_q[k]  <= length[k*BWLENGTH +: BWLENGTH];
         end
      end
   end

   // Counters and registered addresses: seeded at start, stepped on each consumed non-final address.
   // The final address is left in place so the outputs keep the last value after the job.
   always_ff @(posedge clk) begin
      if (clr) begin
         bd_q    <= '0;
         bw_q    <= '0;
         iaddr_q <= '0;
         waddr_q <= '0;
         for (int k = 0; k < NDIM; k++) begin
            c_q[k]    <= '0;
            ioff_q[k] <= '0;
            woff_q[k] <= '0;
         end
      end else if (state_q == ST_IDLE && start) begin
         bd_q    <= '0;
         bw_q    <= '0;
         iaddr_q <= ibaseaddr;
         waddr_q <= wbaseaddr;
         for (int k = 0; k < NDIM; k++) begin
            c_q[k]    <= '0;
            ioff_q[k] <= '0;
            woff_q[k] <= '0;
         end
      end else if (adv && !last) begin
         bd_q    <= bd_d;
         bw_q    <= bw_d;
         iaddr_q <= iaddr_d;
         waddr_q <= waddr_d;
         for (int k = 0; k < NDIM; k++) begin
            c_q[k]    <= c_d[k];
            ioff_q[k] <= ioff_d[k];
            woff_q[k] <= woff_d[k];
         end
      end
   end

endmodule
